// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-channel TDM serial demultiplexer with word-sync tracking
module tdm_demux4 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         din,
   input  logic         sync,
   output logic [W-1:0] ch_a,
   output logic [W-1:0] ch_b,
   output logic [W-1:0] ch_c,
   output logic [W-1:0] ch_d,
   output logic         word_valid,
   output logic         locked,
   output logic         sync_err
);

   localparam int BCW = $clog2(W);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state_q, state_d;
   logic [1:0]     slot_q;
   logic [BCW-1:0] bitcnt_q;
   logic [W-1:0]   sh_a, sh_b, sh_c, sh_d;

   // The bit that starts a word (fresh lock or resync) is always A, bit 0.
   logic take_a0;
   logic resync_err;
   logic shift;
   logic last;

   // FSM state register; locked is simply "in RUN", so it clears with reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-cycle datapath controls; nothing happens when en=0.
   always_comb begin
      state_d    = state_q;
      take_a0    = 1'b0;
      resync_err = 1'b0;
      shift      = 1'b0;
      last       = 1'b0;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (sync) begin
                  state_d = RUN;
                  take_a0 = 1'b1;
               end
            end
            RUN: begin
               if (sync && (slot_q != 2'd0 || bitcnt_q != '0)) begin
                  take_a0    = 1'b1;
                  resync_err = 1'b1;
               end else begin
                  shift = 1'b1;
                  last  = (slot_q == 2'd3) && (bitcnt_q == LAST_BIT);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Slot/bit counters, per-channel shift registers and output word registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q     <= 2'd0;
         bitcnt_q   <= '0;
         sh_a       <= '0;
         sh_b       <= '0;
         sh_c       <= '0;
         sh_d       <= '0;
         ch_a       <= '0;
         ch_b       <= '0;
         ch_c       <= '0;
         ch_d       <= '0;
         word_valid <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         sync_err   <= 1'b0;
         if (take_a0) begin
            sh_a     <= {sh_a[W-2:0], din};
            slot_q   <= 2'd1;
            bitcnt_q <= '0;
            sync_err <= resync_err;
         end else if (shift) begin
            case (slot_q)
               2'd0:    sh_a <= {sh_a[W-2:0], din};
               2'd1:    sh_b <= {sh_b[W-2:0], din};
               2'd2:    sh_c <= {sh_c[W-2:0], din};
               default: sh_d <= {sh_d[W-2:0], din};
            endcase
            slot_q <= slot_q + 2'd1;
            if (slot_q == 2'd3) begin
               bitcnt_q <= last ? '0 : bitcnt_q + BCW'(1);
            end
            if (last) begin
               ch_a       <= sh_a;
               ch_b       <= sh_b;
               ch_c       <= sh_c;
               ch_d       <= {sh_d[W-2:0], din};
               word_valid <= 1'b1;
            end
         end
      end
   end

   assign locked = (state_q == RUN);

endmodule
